// File: rtl/udp_echo_64_if.sv
// UDP frame bus: header handshake with IP/UDP fields plus a 64-bit AXI-Stream payload.
// The master drives the frame and the slave drives both ready signals.
interface udp_echo_64_if;
  logic        hdr_valid;
  logic        hdr_ready;
  logic [5:0]  ip_dscp;
  logic [1:0]  ip_ecn;
  logic [7:0]  ip_ttl;
  logic [31:0] ip_source_ip;
  logic [31:0] ip_dest_ip;
  logic [15:0] source_port;
  logic [15:0] dest_port;
  logic [15:0] length;
  logic [15:0] checksum;
  logic [63:0] payload_axis_tdata;
  logic [7:0]  payload_axis_tkeep;
  logic        payload_axis_tvalid;
  logic        payload_axis_tlast;
  logic        payload_axis_tuser;
  logic        payload_axis_tready;

  modport master (
    output hdr_valid, ip_dscp, ip_ecn, ip_ttl, ip_source_ip, ip_dest_ip,
           source_port, dest_port, length, checksum,
           payload_axis_tdata, payload_axis_tkeep, payload_axis_tvalid,
           payload_axis_tlast, payload_axis_tuser,
    input  hdr_ready, payload_axis_tready
  );

  modport slave (
    input  hdr_valid, ip_dscp, ip_ecn, ip_ttl, ip_source_ip, ip_dest_ip,
           source_port, dest_port, length, checksum,
           payload_axis_tdata, payload_axis_tkeep, payload_axis_tvalid,
           payload_axis_tlast, payload_axis_tuser,
    output hdr_ready, payload_axis_tready
  );
endinterface

// File: rtl/udp_echo_64.sv
// UDP loopback responder: echoes frames addressed to LISTEN_PORT with addresses/ports swapped,
// payload cut through a small FIFO; all other frames are drained and counted.
module udp_echo_64 #(
  parameter logic [15:0] LISTEN_PORT = 16'd1234,
  parameter logic [7:0]  TTL         = 8'd64,
  parameter int          FIFO_DEPTH  = 16
) (
  input  logic          clk,
  input  logic          rst,
  udp_echo_64_if.slave  s_udp,
  udp_echo_64_if.master m_udp,
  output logic [15:0]   echo_count,
  output logic [15:0]   drop_count
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int FW = 74;
  localparam logic [AW:0] DEPTH_CNT = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, ECHO, DROP} state_t;

  state_t        state_q, state_d;
  logic          hdrReady_q;
  logic          mHdrValid_q, mHdrValid_d;
  logic          hdrSent_q, hdrSent_d;
  logic          inDone_q, inDone_d;
  logic [15:0]   echoCount_q, echoCount_d;
  logic [15:0]   dropCount_q, dropCount_d;
  logic [31:0]   srcIp_q, dstIp_q;
  logic [15:0]   srcPort_q, dstPort_q, length_q;
  logic [FW-1:0] mem [FIFO_DEPTH];
  logic [AW:0]   wrPtr_q, rdPtr_q;
  logic [FW-1:0] outWord_q;
  logic          outValid_q;
  logic          fifoFull, fifoEmpty;
  logic          hdrFire, inTready, inFire, wrEn, rdEn, outFire, mHdrFire;
  logic          unusedRx;

  assign unusedRx  = ^{s_udp.ip_dscp, s_udp.ip_ecn, s_udp.ip_ttl, s_udp.checksum};

  assign fifoEmpty = (wrPtr_q == rdPtr_q);
  assign fifoFull  = ((wrPtr_q - rdPtr_q) == DEPTH_CNT);
  assign hdrFire   = s_udp.hdr_valid && hdrReady_q;
  assign inTready  = ((state_q == ECHO) && !fifoFull && !inDone_q) || (state_q == DROP);
  assign inFire    = s_udp.payload_axis_tvalid && inTready;
  assign wrEn      = inFire && (state_q == ECHO);
  assign mHdrFire  = mHdrValid_q && m_udp.hdr_ready;
  assign outFire   = outValid_q && m_udp.payload_axis_tready;
  // Reads wait for the header to go out so payload can never overtake it.
  assign rdEn      = !fifoEmpty && hdrSent_q && (!outValid_q || m_udp.payload_axis_tready);

  always_comb begin
    state_d     = state_q;
    mHdrValid_d = mHdrValid_q;
    hdrSent_d   = hdrSent_q;
    inDone_d    = inDone_q;
    echoCount_d = echoCount_q;
    dropCount_d = dropCount_q;
    case (state_q)
      IDLE: begin
        if (hdrFire) begin
          if ((s_udp.dest_port == LISTEN_PORT) && (s_udp.length >= 16'd8)) begin
            state_d     = ECHO;
            mHdrValid_d = 1'b1;
          end else begin
            state_d = DROP;
          end
        end
      end
      ECHO: begin
        if (inFire && s_udp.payload_axis_tlast) inDone_d = 1'b1;
        if (mHdrFire) begin
          mHdrValid_d = 1'b0;
          hdrSent_d   = 1'b1;
        end
        if (outFire && outWord_q[1]) begin
          state_d     = IDLE;
          hdrSent_d   = 1'b0;
          inDone_d    = 1'b0;
          echoCount_d = (echoCount_q == 16'hFFFF) ? echoCount_q : echoCount_q + 16'd1;
        end
      end
      DROP: begin
        if (inFire && s_udp.payload_axis_tlast) begin
          state_d     = IDLE;
          dropCount_d = (dropCount_q == 16'hFFFF) ? dropCount_q : dropCount_q + 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      hdrReady_q  <= 1'b0;
      mHdrValid_q <= 1'b0;
      hdrSent_q   <= 1'b0;
      inDone_q    <= 1'b0;
      echoCount_q <= 16'd0;
      dropCount_q <= 16'd0;
      srcIp_q     <= 32'd0;
      dstIp_q     <= 32'd0;
      srcPort_q   <= 16'd0;
      dstPort_q   <= 16'd0;
      length_q    <= 16'd0;
      wrPtr_q     <= '0;
      rdPtr_q     <= '0;
      outValid_q  <= 1'b0;
      outWord_q   <= '0;
    end else begin
      state_q     <= state_d;
      hdrReady_q  <= (state_d == IDLE);
      mHdrValid_q <= mHdrValid_d;
      hdrSent_q   <= hdrSent_d;
      inDone_q    <= inDone_d;
      echoCount_q <= echoCount_d;
      dropCount_q <= dropCount_d;
      if (hdrFire) begin
        srcIp_q   <= s_udp.ip_source_ip;
        dstIp_q   <= s_udp.ip_dest_ip;
        srcPort_q <= s_udp.source_port;
        dstPort_q <= s_udp.dest_port;
        length_q  <= s_udp.length;
      end
      if (wrEn) wrPtr_q <= wrPtr_q + 1'b1;
      if (rdEn) begin
        rdPtr_q    <= rdPtr_q + 1'b1;
        outWord_q  <= mem[rdPtr_q[AW-1:0]];
        outValid_q <= 1'b1;
      end else if (outFire) begin
        outValid_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wrEn) begin
      mem[wrPtr_q[AW-1:0]] <= {s_udp.payload_axis_tdata, s_udp.payload_axis_tkeep,
                               s_udp.payload_axis_tlast, s_udp.payload_axis_tuser};
    end
  end

  assign s_udp.hdr_ready           = hdrReady_q;
  assign s_udp.payload_axis_tready = inTready;

  assign m_udp.hdr_valid           = mHdrValid_q;
  assign m_udp.ip_dscp             = 6'd0;
  assign m_udp.ip_ecn              = 2'd0;
  assign m_udp.ip_ttl              = TTL;
  assign m_udp.ip_source_ip        = dstIp_q;
  assign m_udp.ip_dest_ip          = srcIp_q;
  assign m_udp.source_port         = dstPort_q;
  assign m_udp.dest_port           = srcPort_q;
  assign m_udp.length              = length_q;
  assign m_udp.checksum            = 16'd0;
  assign m_udp.payload_axis_tdata  = outWord_q[73:10];
  assign m_udp.payload_axis_tkeep  = outWord_q[9:2];
  assign m_udp.payload_axis_tlast  = outWord_q[1];
  assign m_udp.payload_axis_tuser  = outWord_q[0];
  assign m_udp.payload_axis_tvalid = outValid_q;

  assign echo_count = echoCount_q;
  assign drop_count = dropCount_q;
endmodule

// File: tb/tb_udp_echo_64.sv
// Bench for udp_echo_64: directed frames against a queue model of expected headers and beats,
// checked by one monitor every cycle plus literal checks that pin the model.
`timescale 1ns/1ps
module tb_udp_echo_64;
  logic clk = 1'b0;
  logic rst;
  logic [15:0] echoCount, dropCount;

  always #5 clk = ~clk;

  udp_echo_64_if rxIf ();
  udp_echo_64_if txIf ();

  udp_echo_64 #(.LISTEN_PORT(16'd1234), .TTL(8'd64), .FIFO_DEPTH(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .s_udp      (rxIf),
    .m_udp      (txIf),
    .echo_count (echoCount),
    .drop_count (dropCount)
  );

  int testsRun = 0;
  int failCount = 0;
  int modelEcho = 0;
  int modelDrop = 0;
  int inAccepted = 0;
  int hdrOut = 0;
  int framesOut = 0;
  logic [143:0] expHdrQ[$];
  logic [73:0]  expBeatQ[$];
  logic [143:0] curHdr, prevHdr, lastHdr;
  logic [73:0]  curBeat, prevBeat;
  logic prevHdrHold = 1'b0;
  logic prevPayHold = 1'b0;
  logic lastTuser = 1'b0;
  logic hdrReadyEn = 1'b1;
  logic hdrRandom = 1'b0;
  int   tReadyMode = 0;

  task automatic checkOutput(input string name, input logic [143:0] act, input logic [143:0] exp);
    testsRun++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Sink-side ready generation: always, random, or held off.
  always @(negedge clk) begin
    case (tReadyMode)
      0:       txIf.payload_axis_tready = 1'b1;
      1:       txIf.payload_axis_tready = 1'($urandom_range(0, 1));
      default: txIf.payload_axis_tready = 1'b0;
    endcase
    txIf.hdr_ready = hdrReadyEn && (!hdrRandom || 1'($urandom_range(0, 1)));
  end

  // Monitor samples one time unit before each rising edge.
  always @(negedge clk) begin
    #4;
    if (rst) begin
      prevHdrHold = 1'b0;
      prevPayHold = 1'b0;
    end else begin
      curHdr  = {txIf.ip_source_ip, txIf.ip_dest_ip, txIf.source_port, txIf.dest_port,
                 txIf.length, txIf.checksum, txIf.ip_ttl, txIf.ip_dscp, txIf.ip_ecn};
      curBeat = {txIf.payload_axis_tdata, txIf.payload_axis_tkeep,
                 txIf.payload_axis_tlast, txIf.payload_axis_tuser};
      if (prevHdrHold) begin
        checkOutput("hdr valid held", 144'(txIf.hdr_valid), 144'd1);
        checkOutput("hdr fields held", curHdr, prevHdr);
      end
      if (prevPayHold) begin
        checkOutput("tvalid held", 144'(txIf.payload_axis_tvalid), 144'd1);
        checkOutput("beat held", 144'(curBeat), 144'(prevBeat));
      end
      if (rxIf.payload_axis_tvalid && rxIf.payload_axis_tready) inAccepted++;
      if (txIf.payload_axis_tvalid && txIf.payload_axis_tready) begin
        checkOutput("payload after hdr", 144'(hdrOut > framesOut), 144'd1);
        checkOutput("beat pending", 144'(expBeatQ.size() != 0), 144'd1);
        if (expBeatQ.size() != 0) checkOutput("beat", 144'(curBeat), 144'(expBeatQ.pop_front()));
        if (txIf.payload_axis_tlast) begin
          framesOut++;
          lastTuser = txIf.payload_axis_tuser;
        end
      end
      if (txIf.hdr_valid && txIf.hdr_ready) begin
        checkOutput("hdr pending", 144'(expHdrQ.size() != 0), 144'd1);
        if (expHdrQ.size() != 0) checkOutput("hdr fields", curHdr, expHdrQ.pop_front());
        lastHdr = curHdr;
        hdrOut++;
      end
      prevHdrHold = txIf.hdr_valid && !txIf.hdr_ready;
      prevHdr     = curHdr;
      prevPayHold = txIf.payload_axis_tvalid && !txIf.payload_axis_tready;
      prevBeat    = curBeat;
    end
  end

  // Tasks below are entered and left on a falling edge.
  task automatic sendHeader(input logic [31:0] sip, input logic [31:0] dip,
                            input logic [15:0] sp, input logic [15:0] dp, input logic [15:0] len);
    int   waitCyc = 0;
    logic acc = 1'b0;
    rxIf.hdr_valid    = 1'b1;
    rxIf.ip_source_ip = sip;
    rxIf.ip_dest_ip   = dip;
    rxIf.source_port  = sp;
    rxIf.dest_port    = dp;
    rxIf.length       = len;
    while (!acc && waitCyc < 300) begin
      #4;
      acc = rxIf.hdr_ready;
      @(negedge clk);
      waitCyc++;
    end
    rxIf.hdr_valid = 1'b0;
    checkOutput("hdr accepted", 144'(acc), 144'd1);
  endtask

  task automatic sendBeat(input logic [73:0] beat);
    int   waitCyc = 0;
    logic acc = 1'b0;
    {rxIf.payload_axis_tdata, rxIf.payload_axis_tkeep,
     rxIf.payload_axis_tlast, rxIf.payload_axis_tuser} = beat;
    rxIf.payload_axis_tvalid = 1'b1;
    while (!acc && waitCyc < 300) begin
      #4;
      acc = rxIf.payload_axis_tready;
      @(negedge clk);
      waitCyc++;
    end
    rxIf.payload_axis_tvalid = 1'b0;
    if (!acc) checkOutput("beat accepted", 144'(acc), 144'd1);
  endtask

  // Builds a frame, records what the echo must look like, then drives it.
  task automatic applyStimulus(input logic [31:0] sip, input logic [31:0] dip,
                               input logic [15:0] sp, input logic [15:0] dp,
                               input int nbytes, input logic userLast);
    logic [73:0] beats[$];
    int   n   = (nbytes + 7) / 8;
    int   rem = nbytes - 8 * (n - 1);
    logic [15:0] len = 16'(8 + nbytes);
    for (int i = 0; i < n; i++) begin
      logic [63:0] d = {32'($urandom), 32'($urandom)};
      logic [7:0]  k = (i == n - 1) ? 8'((1 << rem) - 1) : 8'hFF;
      logic        l = (i == n - 1);
      beats.push_back({d, k, l, l && userLast});
    end
    if (dp == 16'd1234) begin
      expHdrQ.push_back({dip, sip, dp, sp, len, 16'd0, 8'd64, 6'd0, 2'd0});
      foreach (beats[i]) expBeatQ.push_back(beats[i]);
      modelEcho++;
    end else begin
      modelDrop++;
    end
    sendHeader(sip, dip, sp, dp, len);
    foreach (beats[i]) sendBeat(beats[i]);
  endtask

  task automatic waitDrain(input string name);
    int n = 0;
    while ((expHdrQ.size() != 0 || expBeatQ.size() != 0) && n < 6000) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    checkOutput(name, 144'(expHdrQ.size() + expBeatQ.size()), 144'd0);
  endtask

  initial begin
    #800000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int stalled;
    rst = 1'b1;
    rxIf.hdr_valid = 1'b0;
    rxIf.ip_dscp = 6'd0;
    rxIf.ip_ecn = 2'd0;
    rxIf.ip_ttl = 8'd0;
    rxIf.checksum = 16'd0;
    rxIf.ip_source_ip = 32'd0;
    rxIf.ip_dest_ip = 32'd0;
    rxIf.source_port = 16'd0;
    rxIf.dest_port = 16'd0;
    rxIf.length = 16'd0;
    rxIf.payload_axis_tvalid = 1'b0;
    rxIf.payload_axis_tdata = 64'd0;
    rxIf.payload_axis_tkeep = 8'd0;
    rxIf.payload_axis_tlast = 1'b0;
    rxIf.payload_axis_tuser = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset hdr_ready", 144'(rxIf.hdr_ready), 144'd0);
    checkOutput("reset m hdr_valid", 144'(txIf.hdr_valid), 144'd0);
    checkOutput("reset m tvalid", 144'(txIf.payload_axis_tvalid), 144'd0);
    checkOutput("reset s tready", 144'(rxIf.payload_axis_tready), 144'd0);
    checkOutput("reset counters", 144'({echoCount, dropCount}), 144'd0);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("hdr_ready after reset", 144'(rxIf.hdr_ready), 144'd1);

    $display("[TB] frame echo");
    applyStimulus(32'hC0A80164, 32'hC0A80180, 16'd5678, 16'd1234, 16, 1'b0);
    waitDrain("t1 drain");
    checkOutput("t1 hdr literal", lastHdr,
                {32'hC0A80180, 32'hC0A80164, 16'd1234, 16'd5678, 16'd24, 16'd0, 8'd64, 6'd0, 2'd0});
    checkOutput("t1 echo_count", 144'(echoCount), 144'(modelEcho));
    checkOutput("t1 echo literal", 144'(echoCount), 144'd1);

    $display("[TB] frame drop");
    applyStimulus(32'h0A000001, 32'h0A000002, 16'd4000, 16'd80, 24, 1'b0);
    waitDrain("t2 drain");
    checkOutput("t2 drop literal", 144'(dropCount), 144'd1);
    checkOutput("t2 drop model", 144'(dropCount), 144'(modelDrop));
    checkOutput("t2 echo unchanged", 144'(echoCount), 144'd1);

    $display("[TB] header backpressure");
    hdrReadyEn = 1'b0;
    stalled = inAccepted;
    fork
      applyStimulus(32'h0A000003, 32'h0A000004, 16'd7000, 16'd1234, 160, 1'b0);
      begin
        repeat (40) @(negedge clk);
        checkOutput("t3 fifo fill", 144'(inAccepted - stalled), 144'd16);
        checkOutput("t3 s tready low", 144'(rxIf.payload_axis_tready), 144'd0);
        hdrReadyEn = 1'b1;
      end
    join
    waitDrain("t3 drain");
    checkOutput("t3 echo", 144'(echoCount), 144'd2);

    $display("[TB] back-to-back frames");
    tReadyMode = 1;
    hdrRandom = 1'b1;
    for (int f = 0; f < 200; f++) begin
      applyStimulus({24'hC0A802, 8'(f)}, 32'hC0A80101, 16'($urandom), 16'd1234,
                    $urandom_range(1, 64), 1'b0);
    end
    waitDrain("t4 drain");
    checkOutput("t4 echo model", 144'(echoCount), 144'(modelEcho));
    checkOutput("t4 echo literal", 144'(echoCount), 144'd202);

    $display("[TB] reset mid-frame");
    tReadyMode = 2;
    hdrRandom = 1'b0;
    hdrReadyEn = 1'b0;
    sendHeader(32'h0A000005, 32'h0A000006, 16'd1111, 16'd1234, 16'd48);
    sendBeat({64'h1111_2222_3333_4444, 8'hFF, 1'b0, 1'b0});
    sendBeat({64'h5555_6666_7777_8888, 8'hFF, 1'b0, 1'b0});
    rst = 1'b1;
    #1;
    checkOutput("t5 m hdr_valid", 144'(txIf.hdr_valid), 144'd0);
    checkOutput("t5 m tvalid", 144'(txIf.payload_axis_tvalid), 144'd0);
    checkOutput("t5 hdr_ready", 144'(rxIf.hdr_ready), 144'd0);
    checkOutput("t5 counters", 144'({echoCount, dropCount}), 144'd0);
    expHdrQ.delete();
    expBeatQ.delete();
    hdrOut = 0;
    framesOut = 0;
    modelEcho = 0;
    modelDrop = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    tReadyMode = 0;
    hdrReadyEn = 1'b1;
    @(negedge clk);
    applyStimulus(32'h0A000007, 32'h0A000008, 16'd2222, 16'd1234, 20, 1'b0);
    waitDrain("t5 drain");
    checkOutput("t5 echo literal", 144'(echoCount), 144'd1);

    $display("[TB] tuser passthrough");
    applyStimulus(32'h0A000009, 32'h0A00000A, 16'd3333, 16'd1234, 12, 1'b1);
    waitDrain("t6 drain");
    checkOutput("t6 tuser", 144'(lastTuser), 144'd1);
    checkOutput("t6 echo", 144'(echoCount), 144'd2);
    checkOutput("t6 drop", 144'(dropCount), 144'(modelDrop));

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end
endmodule
